// File: rtl/capture_buffer.sv
// Trigger-capture buffer: circular sample memory with post-trigger capture, then
// oldest-first readout over a valid/ready port.
module capture_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned POST_TRIG  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  trigger,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  primed,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PostInit = ADDR_WIDTH'(POST_TRIG);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArmed = 3'd1;
  localparam logic [2:0] StPost  = 3'd2;
  localparam logic [2:0] StLoad  = 3'd3;
  localparam logic [2:0] StRead  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                  primed_q, primed_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_en, rd_load, rd_take;

  assign wr_en   = write_enable && ((state_q == StArmed) || (state_q == StPost));
  assign rd_take = rd_valid_q && rd_ready;
  // Output register refills whenever it is empty or being drained this cycle.
  assign rd_load = (state_q == StRead) && (!rd_valid_q || rd_ready) && (rd_cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    primed_d    = primed_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;

    if (wr_en) begin
      waddr_d = waddr_q + AddrOne;
      if (waddr_q == LastAddr) primed_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StArmed;
          waddr_d  = '0;
          primed_d = 1'b0;
        end
      end
      StArmed: begin
        if (write_enable && trigger) begin
          trig_addr_d = waddr_q;
          if (POST_TRIG == 0) begin
            state_d = StLoad;
          end else begin
            post_cnt_d = PostInit;
            state_d    = StPost;
          end
        end
      end
      StPost: begin
        if (write_enable) begin
          post_cnt_d = post_cnt_q - AddrOne;
          if (post_cnt_q == AddrOne) state_d = StLoad;
        end
      end
      StLoad: begin
        rd_ptr_d = primed_q ? waddr_q : '0;
        rd_cnt_d = primed_q ? DepthCnt : {1'b0, waddr_q};
        state_d  = StRead;
      end
      StRead: begin
        if (rd_load) begin
          rd_data_d  = mem[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_cnt_q == CntOne);
          rd_ptr_d   = rd_ptr_q + AddrOne;
          rd_cnt_d   = rd_cnt_q - CntOne;
        end else if (rd_take) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      primed_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      primed_q    <= primed_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  // Sample memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr_q] <= i_data;
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign waddr     = waddr_q;
  assign trig_addr = trig_addr_q;
  assign primed    = primed_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: table of capture scenarios plus hand-written
// sequences for POST_TRIG=0, reset aborts and ignored arm/trigger.
module tb_capture_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, arm, write_enable, trigger, rd_ready;
  logic [7:0] i_data, rd_data;
  logic       rd_valid, rd_last, primed, busy, done;
  logic [3:0] waddr, trig_addr;

  logic       arm0, we0, trig0, ready0;
  logic [7:0] data0, rd_data0;
  logic       rd_valid0, rd_last0, primed0, busy0, done0;
  logic [3:0] waddr0, trig_addr0;

  capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .POST_TRIG(4)) dut (
    .clk(clk), .reset(reset), .arm(arm), .write_enable(write_enable), .i_data(i_data),
    .trigger(trigger), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .waddr(waddr), .trig_addr(trig_addr), .primed(primed),
    .busy(busy), .done(done)
  );

  capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .POST_TRIG(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm0), .write_enable(we0), .i_data(data0),
    .trigger(trig0), .rd_ready(ready0), .rd_valid(rd_valid0), .rd_data(rd_data0),
    .rd_last(rd_last0), .waddr(waddr0), .trig_addr(trig_addr0), .primed(primed0),
    .busy(busy0), .done(done0)
  );

  typedef struct {
    int         n_pre;      // samples before the trigger sample
    logic [7:0] base;       // value of the first sample
    bit         gaps;       // random write_enable gaps (with trigger held high)
    bit         stall;      // random rd_ready stalls
    bit         noise;      // arm+trigger at arm time, arm/trigger/writes during readout
    logic [3:0] exp_trig;
    bit         exp_primed;
    logic [3:0] exp_waddr;
    logic [7:0] exp_first;
    int         exp_count;
  } scen_t;

  scen_t tbl [6];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input scen_t s);
    logic [3:0] ew;
    bit         ep;
    arm = 1'b1; trigger = s.noise; write_enable = s.noise; i_data = 8'hEE;
    step();
    arm = 1'b0; trigger = 1'b0; write_enable = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_waddr", waddr, 0);
    check("arm_primed", primed, 0);
    ew = '0;
    ep = 1'b0;
    for (int i = 0; i <= s.n_pre + 4; i++) begin
      if (s.gaps && $urandom_range(0, 1) == 1) begin
        write_enable = 1'b0; trigger = 1'b1; i_data = 8'hEE;
        step();
        check("gap_waddr", waddr, ew);
      end
      write_enable = 1'b1; trigger = (i == s.n_pre); i_data = 8'(s.base + i);
      step();
      if (ew == 4'd15) ep = 1'b1;
      ew = ew + 4'd1;
      check("wr_waddr", waddr, ew);
      check("wr_primed", primed, ep);
    end
    write_enable = 1'b0; trigger = 1'b0;
    check("trig_addr", trig_addr, s.exp_trig);
    check("primed", primed, s.exp_primed);
    check("waddr", waddr, s.exp_waddr);
    check("load_busy", busy, 1);
    check("load_valid", rd_valid, 0);
  endtask

  task automatic read_out(input scen_t s);
    int         idx, cyc;
    bit         held, held_last;
    logic [7:0] held_data;
    idx = 0; cyc = 0; held = 1'b0; held_last = 1'b0; held_data = '0;
    while (idx < s.exp_count && cyc < 400) begin
      if (s.noise) begin
        arm = 1'($urandom_range(0, 1)); trigger = 1'($urandom_range(0, 1));
        write_enable = 1'b1; i_data = 8'hCC;
      end
      rd_ready = s.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (held) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, held_data);
        check("stall_last", rd_last, held_last);
      end
      held = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          check("rd_data", rd_data, 8'(s.exp_first + idx));
          check("rd_last", rd_last, (idx == s.exp_count - 1));
          idx++;
        end else begin
          held = 1'b1; held_data = rd_data; held_last = rd_last;
        end
      end
      step();
      cyc++;
    end
    arm = 1'b0; trigger = 1'b0; write_enable = 1'b0; rd_ready = 1'b0;
    check("read_words", idx, s.exp_count);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", rd_valid, 0);
    step();
    check("done_clear", done, 0);
    check("keep_waddr", waddr, s.exp_waddr);
    check("keep_trig", trig_addr, s.exp_trig);
    check("keep_primed", primed, s.exp_primed);
  endtask

  initial begin
    int cyc;
    //               n_pre base   gaps stall noise trig primed waddr first count
    tbl[0] = '{10, 8'h00, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 4'd15, 8'h00, 15};
    tbl[1] = '{40, 8'h00, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1, 4'd13, 8'h1D, 16};
    tbl[2] = '{15, 8'h40, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 4'd4,  8'h44, 16};
    tbl[3] = '{0,  8'hF0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd5,  8'hF0, 5};
    tbl[4] = '{11, 8'hFA, 1'b0, 1'b1, 1'b0, 4'd11, 1'b1, 4'd0,  8'hFA, 16};
    tbl[5] = '{6,  8'h30, 1'b0, 1'b0, 1'b1, 4'd6,  1'b0, 4'd11, 8'h30, 11};

    reset = 1'b0; arm = 1'b0; write_enable = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    i_data = '0; arm0 = 1'b0; we0 = 1'b0; trig0 = 1'b0; ready0 = 1'b0; data0 = '0;
    step();
    step();
    reset = 1'b1;
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_primed", primed, 0);
    check("rst_waddr", waddr, 0);
    check("rst_trig", trig_addr, 0);
    step();

    foreach (tbl[k]) begin
      capture(tbl[k]);
      read_out(tbl[k]);
    end

    // POST_TRIG=0: trigger on the very first sample gives a single-word capture.
    arm0 = 1'b1;
    step();
    arm0 = 1'b0; we0 = 1'b1; trig0 = 1'b1; data0 = 8'h5A;
    step();
    we0 = 1'b0; trig0 = 1'b0; ready0 = 1'b1;
    check("p0_trig", trig_addr0, 0);
    check("p0_waddr", waddr0, 1);
    check("p0_load_valid", rd_valid0, 0);
    step();
    check("p0_read_valid", rd_valid0, 0);
    step();
    check("p0_valid", rd_valid0, 1);
    check("p0_data", rd_data0, 8'h5A);
    check("p0_last", rd_last0, 1);
    step();
    check("p0_done", done0, 1);
    check("p0_end_valid", rd_valid0, 0);
    check("p0_end_busy", busy0, 0);
    ready0 = 1'b0;
    step();
    check("p0_done_clear", done0, 0);

    // Reset during POST, after the buffer has wrapped.
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      write_enable = 1'b1; trigger = (i == 17); i_data = 8'(i);
      step();
    end
    write_enable = 1'b0; trigger = 1'b0;
    check("post_primed", primed, 1);
    check("post_busy", busy, 1);
    reset = 1'b0;
    step();
    check("rpost_busy", busy, 0);
    check("rpost_valid", rd_valid, 0);
    check("rpost_primed", primed, 0);
    check("rpost_waddr", waddr, 0);
    check("rpost_trig", trig_addr, 0);
    check("rpost_done", done, 0);
    reset = 1'b1;
    step();
    check("rpost_done2", done, 0);
    check("rpost_busy2", busy, 0);

    // Reset during READ with the output stalled.
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_enable = 1'b1; trigger = (i == 0); i_data = 8'(8'h70 + i);
      step();
    end
    write_enable = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check("rread_valid", rd_valid, 1);
    check("rread_data", rd_data, 8'h70);
    reset = 1'b0;
    step();
    check("rread_busy", busy, 0);
    check("rread_valid0", rd_valid, 0);
    check("rread_primed", primed, 0);
    check("rread_waddr", waddr, 0);
    check("rread_done", done, 0);
    reset = 1'b1; rd_ready = 1'b1;
    step();
    check("rread_done2", done, 0);
    check("rread_valid2", rd_valid, 0);
    check("rread_busy2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
